// File: rtl/load_store_control.sv
// load_store_control: Moore control FSM sequencing fetch, ld/ldi/st, nop and halt
// with a halt request at instruction boundaries and a completed-instruction counter.
module load_store_control #(
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011,
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic        clock_i,
  input  logic        clear_i,
  input  logic [31:0] IR_i,
  input  logic        stop_i,
  input  logic        resume_i,
  output logic        PCout_o,
  output logic        MARin_o,
  output logic        IncPC_o,
  output logic        Zlowin_o,
  output logic        Zlowout_o,
  output logic        PCin_o,
  output logic        read_o,
  output logic        write_o,
  output logic        MDRin_o,
  output logic        MDRout_o,
  output logic        IRin_o,
  output logic        Gra_o,
  output logic        Grb_o,
  output logic        Rin_o,
  output logic        Rout_o,
  output logic        BAout_o,
  output logic        Yin_o,
  output logic        Cout_o,
  output logic [4:0]  ALU_o,
  output logic        run_o,
  output logic        illegal_o,
  output logic [15:0] instr_count_o
);
  typedef enum logic [4:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_LD4, S_LD5, S_LD6, S_LD7,
    S_LDI4, S_LDI5,
    S_ST4, S_ST5, S_ST6, S_ST7,
    S_HALT
  } state_t;
  state_t      state_q, state_d, bnd;
  logic [15:0] count_q;
  logic        illegal_q, known, done;
  logic [4:0]  op;
  logic        unused_ir;
  assign op        = IR_i[31:27];
  assign unused_ir = ^IR_i[26:0];
  assign known     = op == OP_LD || op == OP_LDI || op == OP_ST || op == OP_NOP || op == OP_HALT;
  assign bnd       = stop_i ? S_HALT : S_T0;
  // Every path that leaves an instruction (boundary or halt opcode) bumps the counter.
  assign done = state_q inside {S_LD7, S_LDI5, S_ST7} ||
                (state_q == S_T3 && op != OP_LD && op != OP_LDI && op != OP_ST);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = op == OP_LD   ? S_LD4  :
                         op == OP_LDI  ? S_LDI4 :
                         op == OP_ST   ? S_ST4  :
                         op == OP_HALT ? S_HALT : bnd;
      S_LD4:   state_d = S_LD5;
      S_LD5:   state_d = S_LD6;
      S_LD6:   state_d = S_LD7;
      S_LDI4:  state_d = S_LDI5;
      S_ST4:   state_d = S_ST5;
      S_ST5:   state_d = S_ST6;
      S_ST6:   state_d = S_ST7;
      S_LD7, S_LDI5, S_ST7: state_d = bnd;
      S_HALT:  state_d = resume_i ? S_T0 : S_HALT;
      default: state_d = S_RESET;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q   <= S_RESET;
      count_q   <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_q + {15'd0, done};
      illegal_q <= state_q == S_T3 && !known;
    end
  end
  assign PCout_o       = state_q == S_T0;
  assign MARin_o       = state_q inside {S_T0, S_LD5, S_ST5};
  assign IncPC_o       = state_q == S_T0;
  assign Zlowin_o      = state_q inside {S_T0, S_LD4, S_LDI4, S_ST4};
  assign Zlowout_o     = state_q inside {S_T1, S_LD5, S_LDI5, S_ST5};
  assign PCin_o        = state_q == S_T1;
  assign read_o        = state_q inside {S_T1, S_LD6};
  assign write_o       = state_q == S_ST7;
  assign MDRin_o       = state_q inside {S_T1, S_LD6, S_ST6};
  assign MDRout_o      = state_q inside {S_T2, S_LD7};
  assign IRin_o        = state_q == S_T2;
  assign Gra_o         = state_q inside {S_LD7, S_LDI5, S_ST6};
  assign Grb_o         = state_q == S_T3;
  assign Rin_o         = state_q inside {S_LD7, S_LDI5};
  assign Rout_o        = state_q == S_ST6;
  assign BAout_o       = state_q == S_T3;
  assign Yin_o         = state_q == S_T3;
  assign Cout_o        = state_q inside {S_LD4, S_LDI4, S_ST4};
  assign ALU_o         = state_q inside {S_LD4, S_LDI4, S_ST4} ? ALU_ADD : 5'b00000;
  assign run_o         = state_q != S_RESET && state_q != S_HALT;
  assign illegal_o     = illegal_q;
  assign instr_count_o = count_q;
endmodule

// File: tb/tb_load_store_control.sv
// tb_load_store_control: scoreboard bench; per-cycle expected strobe words are
// queued when an instruction is issued and popped as the DUT steps through it.
module tb_load_store_control;
  logic        clk = 1'b0, clear = 1'b1, stop = 1'b0, resume = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        pcout, marin, incpc, zlowin, zlowout, pcin, rd, wr, mdrin, mdrout, irin;
  logic        gra, grb, rin, rout, baout, yin, cout, run, ill;
  logic [4:0]  alu;
  logic [15:0] cnt;
  logic [15:0] exp_cnt = 16'h0;
  logic [24:0] obs;
  logic [24:0] sb[$];
  bit          pend_ill = 1'b0;
  int          checks = 0, failures = 0;
  localparam logic [24:0] B_PCOUT = 25'd1 << 24, B_MARIN = 25'd1 << 23, B_INCPC = 25'd1 << 22,
    B_ZLOWIN = 25'd1 << 21, B_ZLOWOUT = 25'd1 << 20, B_PCIN = 25'd1 << 19, B_READ = 25'd1 << 18,
    B_WRITE = 25'd1 << 17, B_MDRIN = 25'd1 << 16, B_MDROUT = 25'd1 << 15, B_IRIN = 25'd1 << 14,
    B_GRA = 25'd1 << 13, B_GRB = 25'd1 << 12, B_RIN = 25'd1 << 11, B_ROUT = 25'd1 << 10,
    B_BAOUT = 25'd1 << 9, B_YIN = 25'd1 << 8, B_COUT = 25'd1 << 7, B_ADD = 25'd3 << 2,
    B_RUN = 25'd1 << 1, B_ILL = 25'd1;
  localparam logic [24:0] E_IDLE = 25'd0,
    E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN | B_RUN,
    E_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN,
    E_T2   = B_MDROUT | B_IRIN | B_RUN,
    E_T3   = B_GRB | B_BAOUT | B_YIN | B_RUN,
    E_X4   = B_COUT | B_ZLOWIN | B_ADD | B_RUN,
    E_LD5  = B_ZLOWOUT | B_MARIN | B_RUN,
    E_LD6  = B_READ | B_MDRIN | B_RUN,
    E_LD7  = B_MDROUT | B_GRA | B_RIN | B_RUN,
    E_LDI5 = B_ZLOWOUT | B_GRA | B_RIN | B_RUN,
    E_ST5  = B_ZLOWOUT | B_MARIN | B_RUN,
    E_ST6  = B_GRA | B_ROUT | B_MDRIN | B_RUN,
    E_ST7  = B_WRITE | B_RUN;
  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, NOP = 5'b11010,
    HLT = 5'b11011, BAD = 5'b11111;
  load_store_control dut (
    .clock_i(clk), .clear_i(clear), .IR_i(ir), .stop_i(stop), .resume_i(resume),
    .PCout_o(pcout), .MARin_o(marin), .IncPC_o(incpc), .Zlowin_o(zlowin), .Zlowout_o(zlowout),
    .PCin_o(pcin), .read_o(rd), .write_o(wr), .MDRin_o(mdrin), .MDRout_o(mdrout), .IRin_o(irin),
    .Gra_o(gra), .Grb_o(grb), .Rin_o(rin), .Rout_o(rout), .BAout_o(baout), .Yin_o(yin),
    .Cout_o(cout), .ALU_o(alu), .run_o(run), .illegal_o(ill), .instr_count_o(cnt)
  );
  assign obs = {pcout, marin, incpc, zlowin, zlowout, pcin, rd, wr, mdrin, mdrout, irin,
                gra, grb, rin, rout, baout, yin, cout, alu, run, ill};
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag);
    @(negedge clk);
    if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, {7'd0, obs}, {7'd0, sb.pop_front()});
  endtask
  // stp: 0 never, 1 only in the final cycle, 2 in every cycle except the final one
  task automatic instr(input logic [4:0] op, input int stp);
    int n;
    sb.push_back(pend_ill ? E_T0 | B_ILL : E_T0);
    sb.push_back(E_T1);
    sb.push_back(E_T2);
    sb.push_back(E_T3);
    if (op == LD) begin
      sb.push_back(E_X4); sb.push_back(E_LD5); sb.push_back(E_LD6); sb.push_back(E_LD7);
    end else if (op == LDI) begin
      sb.push_back(E_X4); sb.push_back(E_LDI5);
    end else if (op == ST) begin
      sb.push_back(E_X4); sb.push_back(E_ST5); sb.push_back(E_ST6); sb.push_back(E_ST7);
    end
    pend_ill = !(op inside {LD, LDI, ST, NOP, HLT});
    n = sb.size();
    ir = {op, 27'h0800075};
    for (int i = 0; i < n; i++) begin
      cyc($sformatf("op%02h_c%0d", op, i));
      stop = (stp == 1 && i == n - 1) || (stp == 2 && i != n - 1);
    end
    @(posedge clk);
    #1;
    stop = 1'b0;
    exp_cnt++;
    check($sformatf("count_op%02h", op), {16'd0, cnt}, {16'd0, exp_cnt});
  endtask
  task automatic halted(input bit s, input bit r);
    sb.push_back(E_IDLE);
    cyc("halt");
    stop = s;
    resume = r;
    @(posedge clk);
    #1;
    stop = 1'b0;
    resume = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    sb.push_back(E_IDLE);
    cyc("reset_held");
    check("reset_count", {16'd0, cnt}, 32'd0);
    clear = 1'b0;
    @(posedge clk);
    #1;
    instr(LD, 0);
    instr(ST, 0);
    instr(LDI, 0);
    instr(NOP, 2);
    instr(BAD, 0);
    instr(NOP, 0);
    instr(LD, 1);
    halted(1'b1, 1'b0);
    halted(1'b0, 1'b1);
    instr(HLT, 0);
    halted(1'b1, 1'b1);
    sb.push_back(E_T0); sb.push_back(E_T1); sb.push_back(E_T2); sb.push_back(E_T3);
    sb.push_back(E_X4); sb.push_back(E_ST5);
    ir = {ST, 27'h0};
    for (int i = 0; i < 6; i++) cyc($sformatf("st_clr_c%0d", i));
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_cnt = 16'h0;
    sb.push_back(E_IDLE);
    cyc("clr_reset");
    check("clr_count", {16'd0, cnt}, 32'd0);
    @(posedge clk);
    #1;
    instr(NOP, 1);
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.count_q;
    exp_cnt = 16'hFFFF;
    halted(1'b0, 1'b1);
    check("preload", {16'd0, cnt}, {16'd0, exp_cnt});
    instr(NOP, 0);
    check("wrap_zero", {16'd0, cnt}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_control.md
LOAD_STORE_CONTROL -- requirements
Module: load_store_control

Interface
REQ-001 Parameter OP_LD, default 5'b00000: ld opcode in IR[31:27].
REQ-002 Parameter OP_LDI, default 5'b00001: ldi opcode.
REQ-003 Parameter OP_ST, default 5'b00010: st opcode.
REQ-004 Parameter OP_NOP, default 5'b11010: nop opcode; OP_HALT, default 5'b11011: halt opcode.
REQ-005 Parameter ALU_ADD, default 5'b00011: ALU select code for address add.
REQ-006 clock  input  1: single clock; all state changes on posedge.
REQ-007 clear  input  1: reset, synchronous, active-high.
REQ-008 IR  input  32: instruction register output from the datapath.
REQ-009 stop  input  1: request halt at the next instruction boundary.
REQ-010 resume  input  1: leave HALT and restart fetch.
REQ-011 PCout, MARin, IncPC, Zlowin, Zlowout, PCin  output  1 each: fetch/address strobes.
REQ-012 read, write, MDRin, MDRout, IRin  output  1 each: memory and IR strobes.
REQ-013 Gra, Grb, Rin, Rout, BAout, Yin, Cout  output  1 each: register-file, Y and immediate strobes.
REQ-014 ALU  output  5: ALU operation select.
REQ-015 run  output  1: high when not in RESET or HALT.
REQ-016 illegal  output  1: one-cycle pulse on undefined opcode.
REQ-017 instr_count  output  16: completed-instruction count.

Function
REQ-018 Moore FSM, one state per clock; every strobe and ALU a pure decode of current state; strobes not listed for a state SHALL be 0, ALU SHALL be 5'b00000 except in T4.
REQ-019 States: RESET, T0, T1, T2, T3, LD4..LD7, LDI4, LDI5, ST4..ST7, HALT.
REQ-020 RESET: all outputs 0; next T0.
REQ-021 T0: PCout, MARin, IncPC, Zlowin. T1: Zlowout, PCin, read, MDRin. T2: MDRout, IRin.
REQ-022 T3 (common to all opcodes): Grb, BAout, Yin; branch at end of T3 on IR[31:27] (IR valid since the T2->T3 edge).
REQ-023 LD4/LDI4/ST4: Cout, Zlowin, ALU=ALU_ADD.
REQ-024 ld: LD5 Zlowout, MARin; LD6 read, MDRin; LD7 MDRout, Gra, Rin; then boundary.
REQ-025 ldi: LDI5 Zlowout, Gra, Rin; then boundary.
REQ-026 st: ST5 Zlowout, MARin; ST6 Gra, Rout, MDRin (read=0); ST7 write; then boundary.
REQ-027 nop: boundary after T3. halt: HALT after T3. Any other opcode: illegal=1 during the cycle after T3 decode, treated as nop.
REQ-028 Boundary: if stop=1 in the final cycle of an instruction, next state HALT, else T0; stop outside that cycle SHALL be ignored (no latching).
REQ-029 instr_count SHALL increment by 1 on each boundary or halt-opcode completion, wrapping 16'hFFFF->0; illegal ops count.
REQ-030 HALT: all strobes 0, run=0; resume=1 -> T0 next cycle; stop and resume both 1 in HALT -> T0.
REQ-031 Latency: ld 8 cycles, ldi 6, st 8, nop 4, T0 to T0.

Reset
REQ-032 clear=1 at any posedge, any state including mid-instruction, SHALL force RESET next cycle, instr_count=0, illegal=0; clear has priority over stop/resume.
REQ-033 While clear held, FSM remains in RESET with all outputs 0.

Verification
REQ-034 clear 1 cycle, IR=ld (32'h0080_0075 class, opcode 00000) -> T0..T3,LD4..LD7,T0; LD4 shows ALU=5'b00011, Zlowin=1; LD6 read=1; instr_count=1.
REQ-035 IR opcode 00010 -> ST6 Rout=1, Gra=1, MDRin=1, read=0; ST7 write=1 only; next T0.
REQ-036 IR opcode 00001 -> LDI5 Zlowout, Gra, Rin; 6 cycles T0 to T0.
REQ-037 stop=1 during LD7 -> HALT, run=0, all strobes 0; resume=1 -> T0 next cycle.
REQ-038 IR opcode 11111 -> illegal=1 one cycle, then T0, instr_count+1; clear asserted in ST5 -> RESET next cycle, write never asserted.
REQ-039 Preload 16'hFFFF count via 65535 nops (or force) then one nop -> instr_count=16'h0000.
